// File: rtl/spi_minion_arbiter_pkg.sv
// Shared types and helpers for the SPI minion arbiter.
// rr_pick works on a fixed maximum width so one function serves every client count.
package spi_minion_arbiter_pkg;

    // Widest client set the round-robin helper supports (ids up to 6 bits).
    localparam int unsigned MaxClients = 64;
    localparam int unsigned MaxIdBits  = 6;

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic                 found;
        logic [MaxIdBits-1:0] idx;
    } rr_pick_t;

    // Client id width.
    function automatic int unsigned calc_abits(input int unsigned num_clients);
        return (num_clients < 2) ? 1 : $clog2(num_clients);
    endfunction

    // Client data width once the id has been packed into the adapter payload.
    function automatic int unsigned calc_dbits(input int unsigned nbits,
                                               input int unsigned num_clients);
        return nbits - 2 - calc_abits(num_clients);
    endfunction

    // First set bit of val searching ptr, ptr+1, ... with an explicit wrap at n.
    function automatic rr_pick_t rr_pick(input logic [MaxClients-1:0] val,
                                         input logic [MaxIdBits-1:0]  ptr,
                                         input int unsigned           n);
        rr_pick_t             res;
        int unsigned          j;
        logic [MaxIdBits-1:0] j_idx;
        res = '0;
        for (int unsigned i = 0; i < MaxClients; i++) begin
            if (i < n && !res.found) begin
                j = 32'(ptr) + i;
                if (j >= n) begin
                    j = j - n;
                end
                j_idx = j[MaxIdBits-1:0];
                if (val[j_idx]) begin
                    res.found = 1'b1;
                    res.idx   = j_idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_minion_arbiter_rr.sv
// Round-robin priority select over client valids, with the registered
// rotation pointer. The pointer moves past the winner only when it is taken.
module spi_minion_arbiter_rr
    import spi_minion_arbiter_pkg::*;
#(
    parameter  int unsigned num_clients = 4,
    localparam int unsigned abits       = calc_abits(num_clients)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [num_clients-1:0] val,
    input  logic                   advance,
    output logic                   found,
    output logic [abits-1:0]       grant,
    output logic [num_clients-1:0] grant_onehot,
    output logic [abits-1:0]       ptr
);

    logic [MaxClients-1:0] val_ext;
    logic [MaxIdBits-1:0]  ptr_ext;
    logic [abits-1:0]      ptr_q;
    rr_pick_t              pick;
    logic                  unused_pick;

    // Priority search starting at the pointer.
    always_comb begin
        val_ext                  = '0;
        val_ext[num_clients-1:0] = val;
        ptr_ext                  = '0;
        ptr_ext[abits-1:0]       = ptr_q;
        pick                     = rr_pick(val_ext, ptr_ext, num_clients);
        found                    = pick.found;
        grant                    = pick.idx[abits-1:0];
        grant_onehot             = '0;
        if (pick.found) begin
            grant_onehot[grant] = 1'b1;
        end
    end

    assign unused_pick = ^pick.idx;

    // Pointer advances to the client after the winner on an accepted grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (grant == abits'(num_clients - 1)) ? '0 : grant + 1'b1;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/spi_minion_arbiter.sv
// Shares one SPI minion adapter between num_clients requesters.
// Upstream: round-robin merge of client packets, tagged with the client id.
// Downstream: adapter packets routed to a client by the id in the payload MSBs.
// Optional build macro SPI_MINION_ARBITER_DROP_CNT_EN adds drop_cnt/drop_seen
// for packets whose id names no client.
module spi_minion_arbiter
    import spi_minion_arbiter_pkg::*;
#(
    parameter  int unsigned nbits       = 8,
    parameter  int unsigned num_clients = 4,
    localparam int unsigned abits       = calc_abits(num_clients),
    localparam int unsigned dbits       = calc_dbits(nbits, num_clients)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [num_clients-1:0]       cli_recv_val,
    output logic [num_clients-1:0]       cli_recv_rdy,
    input  logic [num_clients*dbits-1:0] cli_recv_msg,
    output logic [num_clients-1:0]       cli_send_val,
    input  logic [num_clients-1:0]       cli_send_rdy,
    output logic [dbits-1:0]             cli_send_msg,
    output logic                         adp_recv_val,
    input  logic                         adp_recv_rdy,
    output logic [nbits-3:0]             adp_recv_msg,
    input  logic                         adp_send_val,
    output logic                         adp_send_rdy,
    input  logic [nbits-3:0]             adp_send_msg
`ifdef SPI_MINION_ARBITER_DROP_CNT_EN
    ,
    output logic [7:0]                   drop_cnt,
    output logic                         drop_seen
`endif
);

    // ---------------- Upstream: clients -> adapter ----------------

    state_t                 up_state_q;
    logic [nbits-3:0]       up_msg_q;
    logic                   can_load;
    logic                   up_hs;
    logic                   rr_found;
    logic [abits-1:0]       rr_grant;
    logic [num_clients-1:0] rr_onehot;
    logic [abits-1:0]       rr_ptr;
    logic [dbits-1:0]       up_data;

    spi_minion_arbiter_rr #(
        .num_clients (num_clients)
    ) u_rr (
        .clk          (clk),
        .reset        (reset),
        .val          (cli_recv_val),
        .advance      (up_hs),
        .found        (rr_found),
        .grant        (rr_grant),
        .grant_onehot (rr_onehot),
        .ptr          (rr_ptr)
    );

    // The pointer is only needed inside the arbiter; observed for debug.
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    // The register can take a new packet when empty or being read this cycle.
    always_comb begin
        can_load     = (up_state_q == EMPTY) || ((up_state_q == FULL) && adp_recv_rdy);
        up_hs        = rr_found && can_load;
        cli_recv_rdy = rr_onehot & {num_clients{can_load}};
        up_data      = cli_recv_msg[rr_grant*dbits +: dbits];
    end

    // Upstream output register: load on a client handshake, empty on a bare drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_state_q <= EMPTY;
            up_msg_q   <= '0;
        end else if (up_hs) begin
            up_state_q <= FULL;
            up_msg_q   <= {rr_grant, up_data};
        end else if ((up_state_q == FULL) && adp_recv_rdy) begin
            up_state_q <= EMPTY;
        end
    end

    assign adp_recv_val = (up_state_q == FULL);
    assign adp_recv_msg = up_msg_q;

    // ---------------- Downstream: adapter -> clients ----------------

    state_t           dn_state_q;
    logic [abits-1:0] dn_id_q;
    logic [dbits-1:0] dn_data_q;
    logic [abits-1:0] in_id;
    logic [dbits-1:0] in_data;
    logic             in_id_ok;
    logic             dn_drain;
    logic             dn_hs;

    // A held packet blocks new ones until its own client takes it.
    always_comb begin
        in_id        = adp_send_msg[nbits-3 -: abits];
        in_data      = adp_send_msg[dbits-1:0];
        in_id_ok     = 32'(in_id) < num_clients;
        dn_drain     = (dn_state_q == FULL) && cli_send_rdy[dn_id_q];
        adp_send_rdy = (dn_state_q == EMPTY) || cli_send_rdy[dn_id_q];
        dn_hs        = adp_send_val && adp_send_rdy;
    end

    // Downstream output register: invalid ids are consumed but never loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            dn_state_q <= EMPTY;
            dn_id_q    <= '0;
            dn_data_q  <= '0;
        end else if (dn_hs && in_id_ok) begin
            dn_state_q <= FULL;
            dn_id_q    <= in_id;
            dn_data_q  <= in_data;
        end else if (dn_drain) begin
            dn_state_q <= EMPTY;
        end
    end

    // Valid goes only to the addressed client.
    always_comb begin
        cli_send_val = '0;
        if (dn_state_q == FULL) begin
            cli_send_val[dn_id_q] = 1'b1;
        end
    end

    assign cli_send_msg = dn_data_q;

`ifdef SPI_MINION_ARBITER_DROP_CNT_EN
    logic dn_drop;
    assign dn_drop = dn_hs && !in_id_ok;

    // Saturating count of dropped packets plus a sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt  <= '0;
            drop_seen <= 1'b0;
        end else if (dn_drop) begin
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            drop_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_minion_arbiter.sv
// Directed bench for spi_minion_arbiter: a 4-client instance for the main
// paths and a 3-client instance for invalid-id drops.
module tb_spi_minion_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // 4-client instance (dbits = 4)
    logic [3:0]  cli_recv_val = '0;
    logic [3:0]  cli_recv_rdy;
    logic [15:0] cli_recv_msg = '0;
    logic [3:0]  cli_send_val;
    logic [3:0]  cli_send_rdy = '0;
    logic [3:0]  cli_send_msg;
    logic        adp_recv_val;
    logic        adp_recv_rdy = 1'b0;
    logic [5:0]  adp_recv_msg;
    logic        adp_send_val = 1'b0;
    logic        adp_send_rdy;
    logic [5:0]  adp_send_msg = '0;

    // 3-client instance (abits = 2, dbits = 4)
    logic [2:0]  t3_cli_recv_val = '0;
    logic [2:0]  t3_cli_recv_rdy;
    logic [11:0] t3_cli_recv_msg = '0;
    logic [2:0]  t3_cli_send_val;
    logic [2:0]  t3_cli_send_rdy = '0;
    logic [3:0]  t3_cli_send_msg;
    logic        t3_adp_recv_val;
    logic        t3_adp_recv_rdy = 1'b0;
    logic [5:0]  t3_adp_recv_msg;
    logic        t3_adp_send_val = 1'b0;
    logic        t3_adp_send_rdy;
    logic [5:0]  t3_adp_send_msg = '0;

`ifdef SPI_MINION_ARBITER_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic       drop_seen;
    logic [7:0] t3_drop_cnt;
    logic       t3_drop_seen;
`endif

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    logic [5:0]  exp_msg;

    spi_minion_arbiter #(
        .nbits       (8),
        .num_clients (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cli_recv_val (cli_recv_val),
        .cli_recv_rdy (cli_recv_rdy),
        .cli_recv_msg (cli_recv_msg),
        .cli_send_val (cli_send_val),
        .cli_send_rdy (cli_send_rdy),
        .cli_send_msg (cli_send_msg),
        .adp_recv_val (adp_recv_val),
        .adp_recv_rdy (adp_recv_rdy),
        .adp_recv_msg (adp_recv_msg),
        .adp_send_val (adp_send_val),
        .adp_send_rdy (adp_send_rdy),
        .adp_send_msg (adp_send_msg)
`ifdef SPI_MINION_ARBITER_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt),
        .drop_seen    (drop_seen)
`endif
    );

    spi_minion_arbiter #(
        .nbits       (8),
        .num_clients (3)
    ) dut3 (
        .clk          (clk),
        .reset        (reset),
        .cli_recv_val (t3_cli_recv_val),
        .cli_recv_rdy (t3_cli_recv_rdy),
        .cli_recv_msg (t3_cli_recv_msg),
        .cli_send_val (t3_cli_send_val),
        .cli_send_rdy (t3_cli_send_rdy),
        .cli_send_msg (t3_cli_send_msg),
        .adp_recv_val (t3_adp_recv_val),
        .adp_recv_rdy (t3_adp_recv_rdy),
        .adp_recv_msg (t3_adp_recv_msg),
        .adp_send_val (t3_adp_send_val),
        .adp_send_rdy (t3_adp_send_rdy),
        .adp_send_msg (t3_adp_send_msg)
`ifdef SPI_MINION_ARBITER_DROP_CNT_EN
        ,
        .drop_cnt     (t3_drop_cnt),
        .drop_seen    (t3_drop_seen)
`endif
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_adp_recv_val", 32'(adp_recv_val), 32'd0);
        chk("rst_cli_send_val", 32'(cli_send_val), 32'd0);
        chk("rst_adp_recv_msg", 32'(adp_recv_msg), 32'd0);
        chk("rst_cli_send_msg", 32'(cli_send_msg), 32'd0);
        chk("rst_ptr", 32'(dut.u_rr.ptr_q), 32'd0);
        chk("rst_adp_send_rdy", 32'(adp_send_rdy), 32'd1);

        // Single client 2 with data A
        cli_recv_val = 4'b0100;
        cli_recv_msg = 16'h0A00;
        adp_recv_rdy = 1'b1;
        #1;
        chk("single_cli_rdy", 32'(cli_recv_rdy), 32'h4);
        tick();
        cli_recv_val = 4'b0000;
        #1;
        chk("single_val", 32'(adp_recv_val), 32'd1);
        chk("single_msg", 32'(adp_recv_msg), 32'b10_1010);
        chk("single_ptr", 32'(dut.u_rr.ptr_q), 32'd3);
        tick();
        chk("single_drain", 32'(adp_recv_val), 32'd0);

        // All valid from ptr 0: ids 0,1,2,3,0,1,2,3; client i data = 6+i
        do_reset();
        cli_recv_msg = 16'h9876;
        cli_recv_val = 4'b1111;
        adp_recv_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_msg = {2'(k % 4), 4'(6 + k % 4)};
            chk("rr_val", 32'(adp_recv_val), 32'd1);
            chk("rr_msg", 32'(adp_recv_msg), 32'(exp_msg));
        end

        // Backpressure with id 3 held
        adp_recv_rdy = 1'b0;
        #1;
        chk("bp_cli_rdy", 32'(cli_recv_rdy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_val", 32'(adp_recv_val), 32'd1);
            chk("bp_hold_msg", 32'(adp_recv_msg), 32'b11_1001);
            chk("bp_cli_rdy_hold", 32'(cli_recv_rdy), 32'd0);
        end
        adp_recv_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(cli_recv_rdy), 32'h1);
        tick();
        cli_recv_val = 4'b0000;
        #1;
        chk("bp_next_msg", 32'(adp_recv_msg), 32'b00_0110);
        tick();
        chk("bp_drain", 32'(adp_recv_val), 32'd0);

        // Routing id 1 data 6 into a stalled client
        adp_send_val = 1'b1;
        adp_send_msg = 6'b01_0110;
        cli_send_rdy = 4'b0000;
        #1;
        chk("route_rdy_empty", 32'(adp_send_rdy), 32'd1);
        tick();
        adp_send_msg = 6'b10_1100;
        #1;
        chk("route_val", 32'(cli_send_val), 32'h2);
        chk("route_msg", 32'(cli_send_msg), 32'h6);
        chk("route_stall_rdy", 32'(adp_send_rdy), 32'd0);
        tick();
        chk("route_hold_val", 32'(cli_send_val), 32'h2);
        chk("route_hold_msg", 32'(cli_send_msg), 32'h6);
        cli_send_rdy = 4'b0010;
        #1;
        chk("route_passthru_rdy", 32'(adp_send_rdy), 32'd1);
        tick();
        adp_send_val = 1'b0;
        cli_send_rdy = 4'b0000;
        #1;
        chk("route_refill_val", 32'(cli_send_val), 32'h4);
        chk("route_refill_msg", 32'(cli_send_msg), 32'hC);
        cli_send_rdy = 4'b0100;
        tick();
        cli_send_rdy = 4'b0000;
        #1;
        chk("route_empty", 32'(cli_send_val), 32'd0);

        // Fill both registers, then reset
        cli_recv_val = 4'b0110;
        adp_recv_rdy = 1'b0;
        adp_send_val = 1'b1;
        adp_send_msg = 6'b11_0101;
        tick();
        adp_send_val = 1'b0;
        #1;
        chk("full_up_val", 32'(adp_recv_val), 32'd1);
        chk("full_up_msg", 32'(adp_recv_msg), 32'b01_0111);
        chk("full_dn_val", 32'(cli_send_val), 32'h8);
        chk("full_ptr", 32'(dut.u_rr.ptr_q), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_up_val", 32'(adp_recv_val), 32'd0);
        chk("mid_rst_dn_val", 32'(cli_send_val), 32'd0);
        chk("mid_rst_up_msg", 32'(adp_recv_msg), 32'd0);
        chk("mid_rst_dn_msg", 32'(cli_send_msg), 32'd0);
        chk("mid_rst_ptr", 32'(dut.u_rr.ptr_q), 32'd0);
        chk("mid_rst_grant", 32'(cli_recv_rdy), 32'h2);
        adp_recv_rdy = 1'b1;
        tick();
        cli_recv_val = 4'b0000;
        #1;
        chk("post_rst_msg", 32'(adp_recv_msg), 32'b01_0111);
        chk("post_rst_ptr", 32'(dut.u_rr.ptr_q), 32'd2);
        tick();

        // 3 clients: id 3 twice is dropped, then id 2 routes
`ifdef SPI_MINION_ARBITER_DROP_CNT_EN
        chk("t3_drop_cnt_rst", 32'(t3_drop_cnt), 32'd0);
        chk("t3_drop_seen_rst", 32'(t3_drop_seen), 32'd0);
`endif
        t3_adp_send_val = 1'b1;
        t3_adp_send_msg = 6'b11_0101;
        #1;
        chk("t3_drop_rdy", 32'(t3_adp_send_rdy), 32'd1);
        tick();
        chk("t3_drop1_val", 32'(t3_cli_send_val), 32'd0);
        chk("t3_drop1_rdy", 32'(t3_adp_send_rdy), 32'd1);
        tick();
        t3_adp_send_val = 1'b0;
        #1;
        chk("t3_drop2_val", 32'(t3_cli_send_val), 32'd0);
`ifdef SPI_MINION_ARBITER_DROP_CNT_EN
        chk("t3_drop_cnt", 32'(t3_drop_cnt), 32'd2);
        chk("t3_drop_seen", 32'(t3_drop_seen), 32'd1);
`endif
        t3_adp_send_val = 1'b1;
        t3_adp_send_msg = 6'b10_0011;
        tick();
        t3_adp_send_val = 1'b0;
        #1;
        chk("t3_route_val", 32'(t3_cli_send_val), 32'h4);
        chk("t3_route_msg", 32'(t3_cli_send_msg), 32'h3);
`ifdef SPI_MINION_ARBITER_DROP_CNT_EN
        chk("t3_drop_cnt_keep", 32'(t3_drop_cnt), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/spi_minion_arbiter.md
Name: spi_minion_arbiter

Overview:
- Shares one SPI minion adapter between `num_clients` on-chip requesters.
- Chip-to-master direction: round-robin arbitration among client streams. Each winning packet is tagged with the client ID and presented to the adapter recv interface through a 1-entry output register.
- Master-to-chip direction: packets from the adapter send interface are routed to one client by the ID field in the payload MSBs, through a 1-entry output register.

Parameters:
- nbits, 8, adapter packet width; adapter payload width is nbits-2.
- num_clients, 4, number of requesters, range 2..2^(nbits-3).
- Derived (localparam, not overridable):
  - abits = $clog2(num_clients)
  - dbits = nbits-2-abits

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- cli_recv_val  input  num_clients  client i has a packet for the master
- cli_recv_rdy  output  num_clients  client i packet accepted
- cli_recv_msg  input  num_clients*dbits  client data, client i at bits [i*dbits +: dbits]
- cli_send_val  output  num_clients  packet valid to client i (at most one bit set)
- cli_send_rdy  input  num_clients  client i can accept
- cli_send_msg  output  dbits  routed data, shared by all clients
- adp_recv_val  output  1  tagged packet to adapter
- adp_recv_rdy  input  1  adapter accepts
- adp_recv_msg  output  nbits-2  {id[abits-1:0], data}
- adp_send_val  input  1  packet from adapter
- adp_send_rdy  output  1  arbiter accepts
- adp_send_msg  input  nbits-2  {id, data}

Behaviour:
- Reset: clock clk; reset is synchronous, active-high.
  - adp_recv_val=0, cli_send_val=0, adp_recv_msg=0, cli_send_msg=0.
  - Round-robin pointer ptr=0; both output registers empty.
  - Reset mid-transfer discards buffered packets with no handshake.
- Upstream register: states EMPTY and FULL.
  - can_load = EMPTY | (FULL & adp_recv_rdy).
  - Grant g = first i with cli_recv_val[i], searching ptr, ptr+1, …, wrapping modulo num_clients.
  - cli_recv_rdy = onehot(g) & can_load, combinational. cli_recv_rdy is never asserted for a client whose val is low.
  - On a client handshake: register <= {g, data_g}; state FULL; ptr <= (g+1) mod num_clients.
  - ptr is unchanged if there is no handshake.
  - FULL & adp_recv_rdy with no new grant -> EMPTY.
  - Latency: client handshake to adp_recv_val is 1 cycle. Throughput is 1 packet/cycle with sustained adp_recv_rdy.
  - adp_recv_msg is stable while adp_recv_val=1 and adp_recv_rdy=0.
- Fairness: with all clients continuously valid, grants follow 0,1,…,N-1,0,… and no client waits more than N-1 grants.
- Downstream register: states EMPTY and FULL; holds id and data.
  - cli_send_val = onehot(id) & FULL.
  - can_accept = EMPTY | cli_send_rdy[id].
  - adp_send_rdy = can_accept.
  - On adp_send handshake with id < num_clients: load the register; state FULL.
  - On adp_send handshake with id >= num_clients (only possible when num_clients is not a power of 2): packet is consumed and dropped; the register drains normally.
  - Drain and refill in the same cycle are allowed. Latency 1 cycle.
  - A stalled client blocks only the downstream direction. The upstream direction is independent.
- Both directions may handshake in the same cycle; no interaction between them.
- ID arithmetic is unsigned; ptr wrap is explicit (not power-of-2 modulo).

Optional Feature:
- Macro: SPI_MINION_ARBITER_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt, 8 bits, counting dropped invalid-ID packets.
  - Saturates at 255; cleared by reset.
  - Also adds output drop_seen (sticky 1-bit), set on the first drop.
- Undefined: ports absent; invalid-ID packets are silently dropped.
- Both builds must remain cycle-identical on all other ports.

Decomposition:
- Package spi_minion_arbiter_pkg:
  - typedef state_t {EMPTY, FULL}
  - function rr_pick(val, ptr) returning index and found flag
  - localparam helpers for abits/dbits
- One sub-module, spi_minion_arbiter_rr: pure combinational round-robin priority select plus registered ptr. Reused by both the top and the bench reference model.

Test Plan (nbits=8, num_clients=4, dbits=4 unless noted):
- Single client: cli_recv_val=4'b0100, msg2=4'hA, adp_recv_rdy=1 -> next cycle adp_recv_val=1, adp_recv_msg=6'b10_1010; ptr=3.
- All valid, adp_recv_rdy=1 for 8 cycles -> adapter sees ids 0,1,2,3,0,1,2,3 on consecutive cycles.
- Backpressure: adp_recv_rdy=0 for 3 cycles while FULL -> adp_recv_msg held; cli_recv_rdy=0; on release, next grant follows the previous winner in rotation.
- Routing: adp_send_msg=6'b01_0110 with cli_send_rdy=4'b0000 -> cli_send_val=4'b0010, cli_send_msg=4'h6 held; adp_send_rdy=0. Raise cli_send_rdy[1] -> drains and accepts the next packet in the same cycle.
- num_clients=3, macro defined: adp_send_msg id=2'b11 x2 -> no cli_send_val; drop_cnt=2; drop_seen=1.
- Assert reset while both registers are FULL -> next cycle all val=0, ptr=0, and the first grant goes to the lowest valid id.
